// File: rtl/vco_band_cal.sv
// -----------------------------------------------------------------------------
// vco_band_cal
//
// Band-calibration controller for the analog VCO. A sweep steps the 4-bit band
// select through codes 0..15. For each code it waits a settling interval, then
// counts rising edges of the divided VCO output over a fixed window of
// reference-clock cycles. It keeps the code whose count lies closest to the
// programmed target and drives that code onto the VCO select lines. When no
// sweep is running, firmware can force a band with the manual override.
//
// Parameters
//   CNT_W          width of the edge counter, the target and the error values
//   SETTLE_CYCLES  cycles waited after each band change before counting
//   WIN_CYCLES     cycles in each measurement window
//
// Ports
//   clk           reference clock; all state changes on its rising edge
//   resetb        asynchronous active-low reset
//   start         one-cycle sweep request, honoured only when idle
//   abort         stops a running sweep; ignored when idle
//   target_count  desired edge count per window, captured when a sweep starts
//   manual_en     when idle, vsel follows manual_sel instead of cal_code
//   manual_sel    band code forced by firmware
//   vco_div_in    divided VCO output, asynchronous to clk
//   vsel          band code to the VCO (bit0 -> vsel0 ... bit3 -> vsel3)
//   busy          high while a sweep is running
//   done          one-cycle pulse when a sweep finishes normally
//   cal_code      best code found by the last completed sweep
//   best_err      |count - target| belonging to cal_code
//   meas_count    edge count of the most recent window
// -----------------------------------------------------------------------------
module vco_band_cal #(
  parameter int CNT_W         = 16,
  parameter int SETTLE_CYCLES = 16,
  parameter int WIN_CYCLES    = 1024
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] target_count,
  input  logic             manual_en,
  input  logic [3:0]       manual_sel,
  input  logic             vco_div_in,
  output logic [3:0]       vsel,
  output logic             busy,
  output logic             done,
  output logic [3:0]       cal_code,
  output logic [CNT_W-1:0] best_err,
  output logic [CNT_W-1:0] meas_count
);

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] WIN_LAST    = 16'(WIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_MEASURE,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  // Saturating increment: the edge counter sticks at all-ones instead of
  // wrapping, so a very fast band never looks like a slow one.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) return v;
    return v + CNT_W'(1);
  endfunction

  // Unsigned distance; subtracting the smaller operand avoids any overflow.
  function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
    if (a >= b) return a - b;
    return b - a;
  endfunction

  logic             div_p0, div_p1, div_p2;
  logic             rise_det;
  logic [15:0]      timer;
  logic [3:0]       code;
  logic [CNT_W-1:0] target_q;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       best_code;
  logic [CNT_W-1:0] best_err_run;
  logic [CNT_W-1:0] err_cmp;
  logic             better;
  logic [3:0]       cand_code;
  logic [CNT_W-1:0] cand_err;
  logic [3:0]       idle_sel;
  logic             settle_last;
  logic             win_last;

  // ---- stage p0..p2: synchronizer plus edge-history flop ----
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      div_p0 <= 1'b0;
      div_p1 <= 1'b0;
      div_p2 <= 1'b0;
    end else begin
      div_p0 <= vco_div_in;
      div_p1 <= div_p0;
      div_p2 <= div_p1;
    end
  end

  assign rise_det = div_p1 & ~div_p2;

  assign settle_last = (timer == SETTLE_LAST);
  assign win_last    = (timer == WIN_LAST);

  // Strict less-than keeps the earlier (lower) code on a tie.
  assign err_cmp   = abs_diff(cnt, target_q);
  assign better    = (err_cmp < best_err_run);
  assign cand_code = better ? code : best_code;
  assign cand_err  = better ? err_cmp : best_err_run;

  assign idle_sel = manual_en ? manual_sel : cal_code;

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // ---- control: state register ----
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_SETTLE;
      S_SETTLE: begin
        if (abort)            state_nxt = S_IDLE;
        else if (settle_last) state_nxt = S_MEASURE;
      end
      S_MEASURE: begin
        if (abort)         state_nxt = S_IDLE;
        else if (win_last) state_nxt = S_COMPARE;
      end
      S_COMPARE: begin
        if (abort)              state_nxt = S_IDLE;
        else if (code == 4'd15) state_nxt = S_DONE;
        else                    state_nxt = S_SETTLE;
      end
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // ---- sweep datapath: timer, edge count, running best, outputs ----
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      timer        <= '0;
      code         <= '0;
      target_q     <= '0;
      cnt          <= '0;
      best_code    <= '0;
      best_err_run <= '1;
      vsel         <= '0;
      cal_code     <= '0;
      best_err     <= '1;
      meas_count   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            code         <= '0;
            vsel         <= '0;
            target_q     <= target_count;
            best_code    <= '0;
            best_err_run <= '1;
            timer        <= '0;
          end else begin
            vsel <= idle_sel;
          end
        end
        S_SETTLE: begin
          if (abort) begin
            vsel <= idle_sel;
          end else if (settle_last) begin
            timer <= '0;
            cnt   <= '0;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        S_MEASURE: begin
          if (abort) begin
            vsel <= idle_sel;
          end else begin
            // The final window cycle still counts its edge.
            if (rise_det) cnt <= sat_inc(cnt);
            timer <= win_last ? 16'd0 : timer + 16'd1;
          end
        end
        S_COMPARE: begin
          if (abort) begin
            vsel <= idle_sel;
          end else begin
            meas_count   <= cnt;
            best_code    <= cand_code;
            best_err_run <= cand_err;
            if (code == 4'd15) begin
              // Publish the result so it is already valid while done pulses.
              cal_code <= cand_code;
              best_err <= cand_err;
            end else begin
              code <= code + 4'd1;
              vsel <= code + 4'd1;
            end
          end
        end
        S_DONE: begin
          // Hand vsel straight to the idle rule so an active manual
          // override takes effect on the first idle cycle.
          vsel <= manual_en ? manual_sel : best_code;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vco_band_cal.sv
module tb_vco_band_cal;

  localparam int S     = 4;
  localparam int W     = 64;
  localparam int BAND  = S + W + 1;
  localparam int SWEEP = 16 * BAND;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetb, start, abort, manual_en, vco_div_in;
  logic [15:0] target_count;
  logic [3:0]  manual_sel;
  logic [3:0]  vsel, cal_code;
  logic        busy, done;
  logic [15:0] best_err, meas_count;

  logic        start4, vco4, busy4, done4;
  logic [3:0]  target4, vsel4, cal4, err4, meas4;

  vco_band_cal #(.CNT_W(16), .SETTLE_CYCLES(S), .WIN_CYCLES(W)) dut (
    .clk(clk), .resetb(resetb), .start(start), .abort(abort),
    .target_count(target_count), .manual_en(manual_en), .manual_sel(manual_sel),
    .vco_div_in(vco_div_in), .vsel(vsel), .busy(busy), .done(done),
    .cal_code(cal_code), .best_err(best_err), .meas_count(meas_count)
  );

  vco_band_cal #(.CNT_W(4), .SETTLE_CYCLES(S), .WIN_CYCLES(W)) dut4 (
    .clk(clk), .resetb(resetb), .start(start4), .abort(abort),
    .target_count(target4), .manual_en(manual_en), .manual_sel(manual_sel),
    .vco_div_in(vco4), .vsel(vsel4), .busy(busy4), .done(done4),
    .cal_code(cal4), .best_err(err4), .meas_count(meas4)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Value of each VCO input as sampled at rising edge number n.
  bit vlog  [32768];
  bit vlog4 [32768];

  // VCO model: 0 = static low, 1 = period 20-code, 2 = period from tbl (0 = static)
  int mode = 1;
  int tbl [16];
  int ph = 0, ph4 = 0;
  logic [3:0] last_v = 4'd0, last_v4 = 4'd0;

  int mcnt [16];

  typedef struct {
    bit         me;
    logic [3:0] ms;
    bit         ab;
    logic [3:0] ev;
  } vec_t;
  vec_t tv [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int period_of(input int m, input logic [3:0] v);
    if (m == 0) return 0;
    if (m == 1) return 20 - int'(v);
    return tbl[v];
  endfunction

  // Drive the VCO outputs for the next edge (frequency follows the band code
  // the DUT is driving, phase restarts on a band change), then advance one clock.
  task automatic step();
    int p;
    if (vsel !== last_v) begin ph = 0; last_v = vsel; end
    p = period_of(mode, vsel);
    if (p == 0) vco_div_in = 1'b0;
    else begin
      vco_div_in = (ph < p / 2);
      ph = (ph + 1) % p;
    end
    if (vsel4 !== last_v4) begin ph4 = 0; last_v4 = vsel4; end
    p = 17 - int'(vsel4);
    vco4 = (ph4 < p / 2);
    ph4 = (ph4 + 1) % p;
    vlog[cyc + 1]  = vco_div_in;
    vlog4[cyc + 1] = vco4;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // Reference: for each band, count rising edges of the (2-cycle delayed)
  // input inside its window, saturate, pick the closest, first wins ties.
  task automatic model(input int e0, input bit four, input int tgt,
                       output int best, output int berr);
    int cmax, lo, n, e;
    cmax = four ? 15 : 65535;
    best = 0;
    berr = cmax;
    for (int c = 0; c < 16; c++) begin
      lo = e0 + c * BAND + S;
      n = 0;
      for (int k = lo; k < lo + W; k++) begin
        if (four) begin
          if (vlog4[k - 1] && !vlog4[k - 2]) n++;
        end else begin
          if (vlog[k - 1] && !vlog[k - 2]) n++;
        end
      end
      if (n > cmax) n = cmax;
      mcnt[c] = n;
      e = (n > tgt) ? n - tgt : tgt - n;
      if (e < berr) begin
        berr = e;
        best = c;
      end
    end
  endtask

  task automatic run_sweep(input string tag, input int tgt, input bit with4,
                           input int tgt4, input bit abort_with_start, input bit do_abort);
    int e0, acyc, bcyc, dcnt, dcyc, best, berr;
    bit timeout;
    logic [3:0]  prev_cal;
    logic [15:0] prev_err;
    prev_cal = cal_code;
    prev_err = best_err;
    target_count = 16'(tgt);
    start = 1'b1;
    abort = abort_with_start;
    if (with4) begin
      start4  = 1'b1;
      target4 = 4'(tgt4);
    end
    step();
    start = 1'b0; abort = 1'b0; start4 = 1'b0;
    e0 = cyc;
    acyc = do_abort ? e0 + 9 * BAND + S + 10 : -1;
    bcyc = 0; dcnt = 0; dcyc = -1; timeout = 1'b1;
    for (int n = 0; n < SWEEP + 8; n++) begin
      if (!busy) begin timeout = 1'b0; break; end
      bcyc++;
      if (done) begin dcnt++; dcyc = cyc; end
      if ((cyc - e0) < SWEEP && (cyc - e0) % BAND == S)
        chk({tag, " vsel_band"}, 32'(vsel), 32'((cyc - e0) / BAND));
      start = (cyc == e0 + 100);
      if (cyc == e0 + 50) target_count = ~16'(tgt);
      abort = (cyc == acyc);
      step();
    end
    start = 1'b0; abort = 1'b0;
    chk({tag, " timeout"}, 32'(timeout), 32'd0);
    model(e0, 1'b0, tgt, best, berr);
    if (do_abort) begin
      chk({tag, " busy_cycles"}, 32'(bcyc), 32'(acyc - e0 + 1));
      chk({tag, " done_pulses"}, 32'(dcnt), 32'd0);
      chk({tag, " cal_code_kept"}, 32'(cal_code), 32'(prev_cal));
      chk({tag, " best_err_kept"}, 32'(best_err), 32'(prev_err));
      chk({tag, " meas_count"}, 32'(meas_count), 32'(mcnt[8]));
      chk({tag, " vsel_idle"}, 32'(vsel), 32'(manual_en ? manual_sel : prev_cal));
    end else begin
      chk({tag, " busy_cycles"}, 32'(bcyc), 32'(SWEEP + 1));
      chk({tag, " done_pulses"}, 32'(dcnt), 32'd1);
      chk({tag, " done_cycle"}, 32'(dcyc), 32'(e0 + SWEEP));
      chk({tag, " cal_code"}, 32'(cal_code), 32'(best));
      chk({tag, " best_err"}, 32'(best_err), 32'(berr));
      chk({tag, " meas_count"}, 32'(meas_count), 32'(mcnt[15]));
      chk({tag, " vsel_after"}, 32'(vsel), 32'(manual_en ? manual_sel : 4'(best)));
    end
    if (with4) begin
      model(e0, 1'b1, tgt4, best, berr);
      chk({tag, " sat_cal_code"}, 32'(cal4), 32'(best));
      chk({tag, " sat_best_err"}, 32'(err4), 32'(berr));
      chk({tag, " sat_meas"}, 32'(meas4), 32'(mcnt[15]));
    end
  endtask

  initial begin
    int dn;
    tv[0] = '{1'b1, 4'd11, 1'b0, 4'd11};
    tv[1] = '{1'b1, 4'd11, 1'b1, 4'd11};
    tv[2] = '{1'b0, 4'd11, 1'b0, 4'd0};
    tv[3] = '{1'b1, 4'd3,  1'b1, 4'd3};
    tv[4] = '{1'b1, 4'd15, 1'b0, 4'd15};
    tv[5] = '{1'b0, 4'd9,  1'b1, 4'd0};
    tv[6] = '{1'b1, 4'd0,  1'b0, 4'd0};

    resetb = 1'b0; start = 1'b0; abort = 1'b0; manual_en = 1'b0; manual_sel = 4'd0;
    target_count = 16'd0; vco_div_in = 1'b0;
    start4 = 1'b0; target4 = 4'd0; vco4 = 1'b0;
    #1;

    // Reset held while the VCO input toggles
    repeat (25) step();
    chk("rst vsel", 32'(vsel), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst best_err", 32'(best_err), 32'hFFFF);
    chk("rst cal_code", 32'(cal_code), 32'd0);
    chk("rst meas_count", 32'(meas_count), 32'd0);
    chk("rst best_err4", 32'(err4), 32'hF);
    resetb = 1'b1;
    repeat (5) step();
    chk("post_rst vsel", 32'(vsel), 32'd0);
    chk("post_rst busy", 32'(busy), 32'd0);

    // Idle vsel rule, abort without effect in idle
    for (int i = 0; i < 7; i++) begin
      manual_en = tv[i].me; manual_sel = tv[i].ms; abort = tv[i].ab;
      step();
      chk($sformatf("tbl%0d vsel", i), 32'(vsel), 32'(tv[i].ev));
      chk($sformatf("tbl%0d busy", i), 32'(busy), 32'd0);
    end
    abort = 1'b0;
    manual_sel = 4'd7;
    chk("manual_lag before", 32'(vsel), 32'd0);
    step();
    chk("manual_lag after", 32'(vsel), 32'd7);
    manual_en = 1'b0;
    step();
    chk("manual_off vsel", 32'(vsel), 32'd0);

    // Nominal sweep; abort arriving with start is ignored
    mode = 1;
    run_sweep("nominal", 4, 1'b0, 0, 1'b1, 1'b0);

    // Tie between codes 6 (4 edges) and 7 (8 edges) at target 6; saturation on dut4
    mode = 2;
    for (int c = 0; c < 16; c++) tbl[c] = 0;
    tbl[6] = 16; tbl[7] = 8;
    run_sweep("tie", 6, 1'b1, 15, 1'b0, 1'b0);
    chk("tie cal_code", 32'(cal_code), 32'd6);
    chk("tie best_err", 32'(best_err), 32'd2);
    chk("sat first code", 32'(cal4), 32'd13);
    chk("sat meas15", 32'(meas4), 32'd15);

    // Static input, target 0
    mode = 0;
    run_sweep("static", 0, 1'b0, 0, 1'b0, 1'b0);
    chk("static cal_code", 32'(cal_code), 32'd0);
    chk("static best_err", 32'(best_err), 32'd0);

    // Sweep leaving cal_code=4, then abort in code 9 measurement
    mode = 2;
    for (int c = 0; c < 16; c++) tbl[c] = 0;
    tbl[4] = 16;
    run_sweep("cal4", 4, 1'b0, 0, 1'b0, 1'b0);
    chk("cal4 cal_code", 32'(cal_code), 32'd4);
    run_sweep("abort", 4, 1'b0, 0, 1'b0, 1'b1);
    step();
    chk("abort vsel later", 32'(vsel), 32'd4);
    chk("abort busy later", 32'(busy), 32'd0);

    // Full sweep after abort with manual override held on
    mode = 1;
    manual_en = 1'b1; manual_sel = 4'd11;
    run_sweep("manual", int'($urandom_range(0, 8)), 1'b0, 0, 1'b0, 1'b0);
    chk("manual vsel11", 32'(vsel), 32'd11);

    // Randomized band responses and targets
    for (int r = 0; r < 2; r++) begin
      mode = 2;
      for (int c = 0; c < 16; c++) tbl[c] = int'($urandom_range(0, 24));
      manual_en = 1'($urandom_range(0, 1));
      manual_sel = 4'($urandom_range(0, 15));
      run_sweep($sformatf("rand%0d", r), int'($urandom_range(0, 12)), 1'b0, 0, 1'b0, 1'b0);
    end

    // Reset asserted mid-sweep
    manual_en = 1'b0;
    mode = 1;
    target_count = 16'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (200) step();
    chk("midrst busy_before", 32'(busy), 32'd1);
    resetb = 1'b0;
    #1;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    chk("midrst vsel", 32'(vsel), 32'd0);
    chk("midrst cal_code", 32'(cal_code), 32'd0);
    chk("midrst best_err", 32'(best_err), 32'hFFFF);
    chk("midrst meas_count", 32'(meas_count), 32'd0);
    step();
    resetb = 1'b1;
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done || busy) dn++;
    end
    chk("midrst no_activity", 32'(dn), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vco_band_cal.md
Name: vco_band_cal

Overview:
- Digital band-calibration controller for the analog VCO with frequency dividers.
- Sweeps the 4-bit band select (drives vsel0..vsel3) over codes 0..15 and counts rising edges of the divided VCO output (out_div128 or out_div256) over a fixed reference-clock window.
- Latches the code whose count is closest to a programmed target and holds it on the VCO select lines.
- Also supports a manual override so firmware can force a band directly.

Parameters:
- CNT_W, 16, width of edge counter, target and error values.
- SETTLE_CYCLES, 16, reference-clock cycles waited after each band change before counting (1..65535).
- WIN_CYCLES, 1024, reference-clock cycles in each measurement window (1..65535).

Ports:
- clk  input  1  reference clock; all state on rising edge.
- resetb  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a sweep; sampled only in IDLE.
- abort  input  1  terminate a sweep in progress; no effect in IDLE.
- target_count  input  CNT_W  desired edge count per window; sampled on accepted start.
- manual_en  input  1  1 = vsel follows manual_sel whenever FSM is IDLE.
- manual_sel  input  4  forced band code.
- vco_div_in  input  1  divided VCO output, asynchronous to clk.
- vsel  output  4  band code to VCO; bit0 -> vsel0 … bit3 -> vsel3.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when a sweep completes normally.
- cal_code  output  4  best code from last completed sweep.
- best_err  output  CNT_W  |count - target| of cal_code.
- meas_count  output  CNT_W  count from most recent window.

Behaviour:
- Reset (async assert, sync-safe release): state=IDLE, vsel=0, busy=0, done=0, cal_code=0, best_err=all ones, meas_count=0, synchronizer flops=0.
- vco_div_in passes through a 2-flop synchronizer plus a third flop. An edge is counted on a cycle where flop2=1 and flop3=0.
- Edge counter saturates at 2^CNT_W-1; it does not wrap.
- States: IDLE, SETTLE, MEASURE, COMPARE, DONE.
- IDLE, start=1:
  - Next cycle enters SETTLE with code=0 and vsel=0.
  - busy=1, target latched, running best cleared to err=all ones, best=0.
- IDLE, start=0: vsel = manual_en ? manual_sel : cal_code. This is registered, so vsel updates 1 cycle after a manual_en/manual_sel change.
- SETTLE:
  - Counts exactly SETTLE_CYCLES cycles; edges are ignored.
  - Then enters MEASURE with the edge counter cleared.
- MEASURE:
  - Counts exactly WIN_CYCLES cycles. Edges detected in any of those cycles are counted, including the last.
  - Then enters COMPARE.
- COMPARE (1 cycle):
  - meas_count <= count; err = |count - target| computed at CNT_W bits, unsigned, no overflow.
  - If err < running best_err: best <= code, best_err <= err. Ties keep the lower code.
  - If code==15, go to DONE; else code+1, vsel updated, go to SETTLE.
- DONE (1 cycle):
  - done=1; cal_code and best_err outputs updated; vsel <= best; busy=0 from the next cycle.
  - Then IDLE.
- Per-band latency: SETTLE_CYCLES+WIN_CYCLES+1 cycles. A full sweep takes 16×(that)+1 cycles from start acceptance to the done pulse.
- start while busy: ignored; it is not queued.
- abort in SETTLE/MEASURE/COMPARE:
  - Next cycle IDLE, busy=0, done not pulsed.
  - cal_code, best_err and meas_count keep their previous values; vsel returns to the IDLE rule.
- start and abort asserted together in IDLE: start wins; abort is ignored.
- manual_en is ignored while busy; the sweep owns vsel.
- resetb asserted mid-sweep: immediate return to reset values; no done pulse.

Test Plan:
- Reset check: hold resetb=0 with vco_div_in toggling -> vsel=0, busy=0, done=0, best_err=16'hFFFF. After release with no start, vsel stays 0.
- Nominal sweep (SETTLE=4, WIN=64, VCO model period per code 20−code clk cycles, target=4):
  - busy=1 for 16×69+1 cycles, then exactly one done pulse.
  - cal_code=code giving count 4 (code 4, period 16), best_err=0, vsel=4 afterwards.
- Tie/boundary:
  - target such that codes 6 and 7 give equal error -> cal_code=6.
  - target=0 with vco_div_in static -> all counts 0, cal_code=0, best_err=0.
- Saturation: CNT_W=4, fast toggling giving >15 edges -> meas_count=15, no wrap. Target 15 selects the first code reaching saturation.
- Abort mid-MEASURE of code 9 after a completed sweep with cal_code=4:
  - busy falls the next cycle, no done pulse, cal_code stays 4, vsel=4.
  - A start pulse during the sweep is ignored; a new start afterwards runs a full sweep.
- Manual override: in IDLE, manual_en=1, manual_sel=11 -> vsel=11 one cycle later. During a sweep vsel follows the sweep code. After done with manual_en still 1, vsel=11 from the cycle after DONE.
